// File: rtl/serial_in_parallel_out_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_in_parallel_out_rx
// Purpose  : Receive end of the serial bit link. It collects an LSB-first
//            serial stream into WIDTH-bit words. Each word is presented on a
//            valid/ready port that has a one-word holding register. The block
//            also flags overrun and framing resync.
// Options  : PARITY_CHECK_EN - each frame carries one trailing even-parity
//            bit. A word is accepted only when the parity holds; otherwise
//            par_err pulses for one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module serial_in_parallel_out_rx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             resync,
  output logic             par_err
);

`ifdef PARITY_CHECK_EN
  localparam int c_frame_len = WIDTH + 1;
`else
  localparam int c_frame_len = WIDTH;
`endif
  localparam int c_cnt_w = $clog2(c_frame_len + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_frame_len - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
  logic [c_frame_len-1:0] r_shreg, w_shreg_nxt, w_shifted;
  logic [WIDTH-1:0]       r_pout, w_pout_nxt;
  logic                   r_pout_valid, w_pout_valid_nxt;
  logic                   r_overrun, w_overrun_nxt;
  logic                   r_resync, w_resync_nxt;
  logic                   r_par_err, w_par_err_nxt;
  logic                   w_complete, w_parity_ok;

  // Bits arrive LSB first, so each new bit enters at the top of the register.
  assign w_shifted = {sin, r_shreg[c_frame_len-1:1]};

`ifdef PARITY_CHECK_EN
  assign w_parity_ok = ~(^w_shifted);
`else
  assign w_parity_ok = 1'b1;
`endif

  // Next state for the framing FSM and the output holding register.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_shreg_nxt      = r_shreg;
    w_complete       = 1'b0;
    w_resync_nxt     = 1'b0;
    w_par_err_nxt    = 1'b0;
    w_pout_nxt       = r_pout;
    w_pout_valid_nxt = r_pout_valid;
    w_overrun_nxt    = r_overrun & ~ovr_clr;

    case (r_state)
      ST_IDLE: begin
        if (sin_valid && frame_start) begin
          w_shreg_nxt = w_shifted;
          w_cnt_nxt   = c_cnt_one;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (sin_valid) begin
          w_shreg_nxt = w_shifted;
          if (frame_start) begin
            // A new frame start drops the partial frame that is in flight.
            w_cnt_nxt    = c_cnt_one;
            w_resync_nxt = 1'b1;
          end else if (r_cnt == c_cnt_last) begin
            w_complete  = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + c_cnt_one;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // A consumer handshake frees the holding register.
    if (r_pout_valid && pout_ready) begin
      w_pout_valid_nxt = 1'b0;
    end

    if (w_complete && !w_parity_ok) begin
      w_par_err_nxt = 1'b1;
    end else if (w_complete) begin
      if (!r_pout_valid || pout_ready) begin
        w_pout_nxt       = w_shifted[WIDTH-1:0];
        w_pout_valid_nxt = 1'b1;
      end else begin
        // The holding register is still full, so the new word is lost.
        // A set on the same edge as ovr_clr takes priority.
        w_overrun_nxt = 1'b1;
      end
    end
  end

  // State and output registers. Reset is asynchronous and clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_pout       <= '0;
      r_pout_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_resync     <= 1'b0;
      r_par_err    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_shreg      <= w_shreg_nxt;
      r_pout       <= w_pout_nxt;
      r_pout_valid <= w_pout_valid_nxt;
      r_overrun    <= w_overrun_nxt;
      r_resync     <= w_resync_nxt;
      r_par_err    <= w_par_err_nxt;
    end
  end

  assign pout       = r_pout;
  assign pout_valid = r_pout_valid;
  assign overrun    = r_overrun;
  assign resync     = r_resync;
  assign par_err    = r_par_err;

endmodule
`default_nettype wire

// File: tb/tb_serial_in_parallel_out_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_in_parallel_out_rx
// Purpose  : Directed testbench for serial_in_parallel_out_rx (WIDTH=4).
//            Expected words go into a scoreboard queue when a frame is sent.
//            They are popped when the DUT presents a word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_in_parallel_out_rx;

  localparam int WIDTH = 4;
`ifdef PARITY_CHECK_EN
  localparam int c_len = WIDTH + 1;
`else
  localparam int c_len = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sin = 1'b0;
  logic             sin_valid = 1'b0;
  logic             frame_start = 1'b0;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             pout_ready = 1'b0;
  logic             overrun;
  logic             ovr_clr = 1'b0;
  logic             resync;
  logic             par_err;

  int               n_cmp = 0;
  int               n_err = 0;
  int               resync_seen = 0;
  logic [WIDTH-1:0] sb_q[$];
  logic [c_len-1:0] fv;

  serial_in_parallel_out_rx #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .frame_start (frame_start),
    .pout        (pout),
    .pout_valid  (pout_valid),
    .pout_ready  (pout_ready),
    .overrun     (overrun),
    .ovr_clr     (ovr_clr),
    .resync      (resync),
    .par_err     (par_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Build the on-wire frame: data bits, then even parity when it is enabled.
  function automatic logic [c_len-1:0] frame_of(input logic [WIDTH-1:0] d);
    logic [c_len-1:0] f;
    f[WIDTH-1:0] = d;
`ifdef PARITY_CHECK_EN
    f[WIDTH] = ^d;
`endif
    return f;
  endfunction

  task automatic send_bit(input logic b, input logic fs);
    sin         = b;
    sin_valid   = 1'b1;
    frame_start = fs;
    tick();
    if (resync === 1'b1) resync_seen++;
    sin         = 1'b0;
    sin_valid   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] d, input int gap);
    logic [c_len-1:0] f;
    f = frame_of(d);
    for (int i = 0; i < c_len; i++) begin
      send_bit(f[i], i == 0);
      if (i < c_len - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          if (resync === 1'b1) resync_seen++;
        end
      end
    end
  endtask

  task automatic check_word(input string tag);
    logic [WIDTH-1:0] e;
    check({tag, "_valid"}, 32'(pout_valid), 32'd1);
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed word %0h with scoreboard empty", tag, pout);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_pout"}, 32'(pout), 32'(e));
    end
  endtask

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #2;
    check("rst_pout", 32'(pout), 32'h0);
    check("rst_valid", 32'(pout_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_resync", 32'(resync), 32'd0);
    check("rst_par_err", 32'(par_err), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // In IDLE, bits without frame_start are ignored.
    pout_ready = 1'b1;
    for (int i = 0; i < c_len + 1; i++) send_bit(1'b1, 1'b0);
    check("idle_ignore_valid", 32'(pout_valid), 32'd0);

    // Test 1: basic frame 0,1,1,0 -> 6, valid for one cycle
    sb_q.push_back(4'h6);
    send_frame(4'h6, 0);
    check_word("t1");
    tick();
    check("t1_valid_drop", 32'(pout_valid), 32'd0);
    check("t1_pout_hold", 32'(pout), 32'h6);

    // Test 2: gaps of three idle cycles between bits
    resync_seen = 0;
    sb_q.push_back(4'h6);
    send_frame(4'h6, 3);
    check_word("t2");
    check("t2_no_resync", 32'(resync_seen), 32'd0);
    tick();

    // Test 3: held word 6, frame 9 dropped -> overrun
    pout_ready = 1'b0;
    sb_q.push_back(4'h6);
    send_frame(4'h6, 0);
    check_word("t3a");
    send_frame(4'h9, 0);
    check("t3_pout_stable", 32'(pout), 32'h6);
    check("t3_valid_held", 32'(pout_valid), 32'd1);
    check("t3_overrun", 32'(overrun), 32'd1);
    pout_ready = 1'b1;
    tick();
    check("t3_valid_drop", 32'(pout_valid), 32'd0);
    check("t3_overrun_sticky", 32'(overrun), 32'd1);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("t3_ovr_clr", 32'(overrun), 32'd0);

    // Completion on the same edge the held word is taken: replaced, no overrun
    pout_ready = 1'b0;
    sb_q.push_back(4'h6);
    send_frame(4'h6, 0);
    check_word("t7a");
    fv = frame_of(4'h9);
    for (int i = 0; i < c_len; i++) begin
      if (i == c_len - 1) pout_ready = 1'b1;
      send_bit(fv[i], i == 0);
    end
    sb_q.push_back(4'h9);
    check_word("t7b");
    check("t7_no_overrun", 32'(overrun), 32'd0);
    tick();
    check("t7_valid_drop", 32'(pout_valid), 32'd0);

    // Test 4: two bits, then a restart with frame 1,0,0,1 -> resync, 9
    pout_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    fv = frame_of(4'h9);
    send_bit(fv[0], 1'b1);
    check("t4_resync_pulse", 32'(resync), 32'd1);
    send_bit(fv[1], 1'b0);
    check("t4_resync_one_cycle", 32'(resync), 32'd0);
    for (int i = 2; i < c_len; i++) send_bit(fv[i], 1'b0);
    sb_q.push_back(4'h9);
    check_word("t4");
    tick();

    // Test 5: reset mid-frame, then a clean frame of A
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    #2 reset = 1'b1;
    #2;
    check("t5_rst_pout", 32'(pout), 32'h0);
    check("t5_rst_valid", 32'(pout_valid), 32'd0);
    reset = 1'b0;
    tick();
    resync_seen = 0;
    sb_q.push_back(4'hA);
    send_frame(4'hA, 0);
    check_word("t5");
    check("t5_no_resync", 32'(resync_seen), 32'd0);
    check("t5_no_par_err", 32'(par_err), 32'd0);
    tick();

`ifdef PARITY_CHECK_EN
    // Test 6: a bad parity bit gives a par_err pulse and no word
    fv = frame_of(4'h6);
    fv[WIDTH] = ~fv[WIDTH];
    for (int i = 0; i < c_len; i++) send_bit(fv[i], i == 0);
    check("t6_par_err", 32'(par_err), 32'd1);
    check("t6_no_valid", 32'(pout_valid), 32'd0);
    tick();
    check("t6_par_err_pulse", 32'(par_err), 32'd0);
`endif

    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
